// File: rtl/divider_pkg.sv
// Shared types for the radix-2 restoring divider.
package divider_pkg;

  // Controller states: wait for a request, iterate, apply signs, present result.
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left by one,
// bring in the next dividend bit, and trial-subtract the divisor magnitude.
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem_in,
  input  logic         shift_in,
  input  logic [N-1:0] divisor_mag,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N+1:0] diff;
  logic         borrow;
  logic         diff_unused;

  // Trial subtraction in N+1 bits; the extra top bit of diff is the borrow.
  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted = {rem_in, shift_in};
    diff    = {1'b0, shifted} - {2'b00, divisor_mag};
    borrow  = diff[N+1];
    q_bit   = ~borrow;
    // A successful subtract leaves diff < divisor, so N bits always suffice.
    rem_out = borrow ? shifted[N-1:0] : diff[N-1:0];
  end

  assign diff_unused = diff[N];

endmodule

// File: rtl/radix2_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, with
// divide-by-zero and signed-overflow flags.
module radix2_divider
  import divider_pkg::*;
#(
  parameter int N    = 8,
  parameter int LOGN = $clog2(N + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t         state;
  state_t         next_state;
  logic [LOGN-1:0] count;
  logic [N-1:0]   rem_reg;
  logic [N-1:0]   acc_reg;
  logic [N-1:0]   dvs_mag_reg;
  logic           q_neg;
  logic           r_neg;
  logic           ovf_pend;

  logic [N-1:0]   dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic           dvd_neg;
  logic           dvs_neg;
  logic           divisor_zero;
  logic           is_overflow;
  logic [N-1:0]   step_rem;
  logic           step_q;

  // Operand magnitudes and special-case detection at the input port.
  always_comb begin
    dvd_neg      = signed_mode & dividend[N-1];
    dvs_neg      = signed_mode & divisor[N-1];
    dvd_mag      = dvd_neg ? -dividend : dividend;
    dvs_mag      = dvs_neg ? -divisor : divisor;
    divisor_zero = (divisor == '0);
    is_overflow  = signed_mode && (dividend == MIN_NEG) && (divisor == '1);
  end

  div_step #(.N(N)) u_step (
    .rem_in      (rem_reg),
    .shift_in    (acc_reg[N-1]),
    .divisor_mag (dvs_mag_reg),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  // State register.
  // NOTE: asynchronous reset sits in the sensitivity list so it acts without
  // a clock edge; sequential state always uses non-blocking assignments.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and status decode.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = divisor_zero ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (count == '0) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latching, iteration datapath, counter and sign fix-up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      rem_reg     <= '0;
      acc_reg     <= '0;
      dvs_mag_reg <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count       <= LOGN'(N - 1);
          rem_reg     <= '0;
          acc_reg     <= dvd_mag;
          dvs_mag_reg <= dvs_mag;
          q_neg       <= dvd_neg ^ dvs_neg;
          r_neg       <= dvd_neg;
          ovf_pend    <= is_overflow;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          // Zero divisor bypasses the iterations with a fixed result.
          if (divisor_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          rem_reg <= step_rem;
          acc_reg <= {acc_reg[N-2:0], step_q};
          if (count != '0) count <= count - 1'b1;
        end
        FIX: begin
          // -MIN/-1 yields magnitude 2^(N-1) with positive sign: wraps to MIN.
          quotient  <= q_neg ? -acc_reg : acc_reg;
          remainder <= r_neg ? -rem_reg : rem_reg;
          overflow  <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_divider.sv
// Scoreboard bench for radix2_divider at N=8 and N=16.
module tb_radix2_divider;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  dvd8 = '0, dvs8 = '0, q8, r8;
  logic        busy8, done8, dbz8, ovf8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0, q16, r16;
  logic        busy16, done16, dbz16, ovf16;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    bit          dbz;
    bit          ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done8_q  = 1'b0;
  bit done16_q = 1'b0;

  radix2_divider #(.N(8)) dut8 (
    .clock       (clock),
    .reset       (reset),
    .start       (start8),
    .signed_mode (sm8),
    .dividend    (dvd8),
    .divisor     (dvs8),
    .quotient    (q8),
    .remainder   (r8),
    .busy        (busy8),
    .done        (done8),
    .div_by_zero (dbz8),
    .overflow    (ovf8)
  );

  radix2_divider #(.N(16)) dut16 (
    .clock       (clock),
    .reset       (reset),
    .start       (start16),
    .signed_mode (sm16),
    .dividend    (dvd16),
    .divisor     (dvs16),
    .quotient    (q16),
    .remainder   (r16),
    .busy        (busy16),
    .done        (done16),
    .div_by_zero (dbz16),
    .overflow    (ovf16)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: compare on each rising done.
  always @(negedge clock) begin
    if (done8 && !done8_q) begin
      if (sb8.size() == 0) begin
        check("spurious_done8", done8, 1'b0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        check("q8", q8, e.q);
        check("r8", r8, e.r);
        check("dbz8", dbz8, e.dbz);
        check("ovf8", ovf8, e.ovf);
        check("lat8", cyc - e.acc + 1, e.lat);
      end
    end
    done8_q = done8;
  end

  // Monitor for the 16-bit instance.
  always @(negedge clock) begin
    if (done16 && !done16_q) begin
      if (sb16.size() == 0) begin
        check("spurious_done16", done16, 1'b0);
      end else begin
        exp_t e;
        e = sb16.pop_front();
        check("q16", q16, e.q);
        check("r16", r16, e.r);
        check("dbz16", dbz16, e.dbz);
        check("ovf16", ovf16, e.ovf);
        check("lat16", cyc - e.acc + 1, e.lat);
      end
    end
    done16_q = done16;
  end

  // Issue one division, scramble operands mid-run, hold start in DONE, release.
  task automatic run(input bit w16, input bit sm, input logic [15:0] dvd, input logic [15:0] dvs,
                     input logic [15:0] eq, input logic [15:0] er, input bit edbz, input bit eovf,
                     input int hold);
    exp_t e;
    bit   got;
    @(negedge clock);
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.ovf = eovf;
    e.lat = edbz ? 1 : (w16 ? 18 : 10);
    e.acc = cyc + 1;
    if (w16) begin
      sm16 = sm; dvd16 = dvd; dvs16 = dvs; start16 = 1'b1;
      sb16.push_back(e);
    end else begin
      sm8 = sm; dvd8 = dvd[7:0]; dvs8 = dvs[7:0]; start8 = 1'b1;
      sb8.push_back(e);
    end
    @(posedge clock);
    #1;
    if (w16) begin
      dvd16 = ~dvd; dvs16 = dvs ^ 16'h5a5a; sm16 = ~sm;
    end else begin
      dvd8 = ~dvd[7:0]; dvs8 = dvs[7:0] ^ 8'h5a; sm8 = ~sm;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (w16 ? done16 : done8) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_done", w16 ? done16 : done8, 1'b1);
      check("hold_q", w16 ? q16 : {8'h00, q8}, eq);
      check("hold_r", w16 ? r16 : {8'h00, r8}, er);
    end
    if (w16) start16 = 1'b0;
    else     start8  = 1'b0;
    @(posedge clock);
    #1;
    check("idle_done", w16 ? done16 : done8, 1'b0);
    check("idle_busy", w16 ? busy16 : busy8, 1'b0);
  endtask

  initial begin
    bit seen;
    #2;
    check("rst_q", q8, 8'h00);
    check("rst_r", r8, 8'h00);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_dbz", dbz8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    //   w16 sm  dividend   divisor    quotient   remainder  dbz ovf hold
    run(0, 0, 16'd255,  16'd100, 16'd2,    16'd55,   0, 0, 0);
    run(0, 0, 16'd255,  16'd10,  16'd25,   16'd5,    0, 0, 3);
    run(0, 1, 16'h00F9, 16'h0002, 16'h00FD, 16'h00FF, 0, 0, 0);
    run(0, 1, 16'h0007, 16'h00FE, 16'h00FD, 16'h0001, 0, 0, 0);
    run(0, 0, 16'd37,   16'd0,   16'h00FF, 16'd37,   1, 0, 1);
    run(0, 1, 16'h0005, 16'h0000, 16'h00FF, 16'h0005, 1, 0, 0);
    run(0, 0, 16'd200,  16'd3,   16'd66,   16'd2,    0, 0, 0);
    run(0, 0, 16'd3,    16'd200, 16'd0,    16'd3,    0, 0, 0);
    run(0, 0, 16'h00AB, 16'd1,   16'h00AB, 16'd0,    0, 0, 0);
    run(0, 1, 16'h0080, 16'h0007, 16'h00EE, 16'h00FE, 0, 0, 0);
    run(0, 1, 16'h0064, 16'h00F9, 16'h00F2, 16'h0002, 0, 0, 0);
    run(0, 1, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 0, 1, 1);

    // Abort in the 4th CALC cycle: outputs clear at once, no done follows.
    @(negedge clock);
    sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
    @(posedge clock);
    repeat (3) @(posedge clock);
    #2;
    check("busy_before_abort", busy8, 1'b1);
    reset  = 1'b1;
    start8 = 1'b0;
    #1;
    check("abort_q", q8, 8'h00);
    check("abort_r", r8, 8'h00);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_ovf", ovf8, 1'b0);
    check("abort_dbz", dbz8, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (done8) seen = 1'b1;
    end
    check("no_done_after_abort", seen, 1'b0);
    run(0, 0, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 0);

    run(1, 0, 16'd65535, 16'd255, 16'd257, 16'd0, 0, 0, 1);
    run(1, 0, 16'd1000,  16'd7,   16'd142, 16'd6, 0, 0, 0);

    repeat (3) @(negedge clock);
    check("sb8_drained", sb8.size(), 0);
    check("sb16_drained", sb16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
